// File: rtl/sisc_pkg.sv
// sisc_pkg: shared widths, opcode field bounds and fetch state for the SISC core
package sisc_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam logic [OPC_HI-OPC_LO:0] HALT_OPC_DEF = 4'hF;
  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/sisc_pc_reg.sv
// sisc_pc_reg: program counter with async active-low reset, priority load > increment > hold
module sisc_pc_reg
  import sisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  // PC update; increment wraps modulo 2^16
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: fetch stage with valid/ready IR handoff and redirect; halt state under SISC_IFETCH_HALT_EN
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0]        RESET_PC = 16'h0000,
  parameter logic [OPC_HI-OPC_LO:0]   HALT_OPC = HALT_OPC_DEF
) (
  input  logic               clk,
  input  logic               rst_f,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               halted
);
  fetch_state_t state, state_nxt;
  logic load;
  logic [ADDR_W-1:0] pc;

  assign load = (state == RUN) && !redirect && (!ir_valid || ir_ready);
  assign im_addr = pc;

  sisc_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_f    (rst_f),
    .load     (redirect),
    .load_val (redirect_addr),
    .inc      (load),
    .pc       (pc)
  );

  // fetch state register
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) state <= RUN;
    else state <= state_nxt;

`ifdef SISC_IFETCH_HALT_EN
  // redirect always resumes; loading a halt word stops further fetch
  always_comb begin
    state_nxt = state;
    state_nxt = redirect ? RUN : (load && im_data[OPC_HI:OPC_LO] == HALT_OPC) ? HALT : state;
  end
  assign halted = (state == HALT);
`else
  // without halt support fetch never leaves RUN
  always_comb begin
    state_nxt = RUN;
  end
  assign halted = 1'b0;
  logic unused_halt_opc;
  assign unused_halt_opc = ^HALT_OPC;
`endif

  // instruction register and its handshake; a redirect discards the held word
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) begin
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      ir_valid <= 1'b0;
    end else if (load) begin
      ir <= im_data;
      ir_pc <= pc;
      ir_valid <= 1'b1;
    end else if (ir_ready) begin
      ir_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: directed timing scenarios plus randomized stream scoreboard for sisc_ifetch
module tb_sisc_ifetch;
  logic clk = 0, rst_f = 0;
  logic [15:0] im_addr, ir_pc, redirect_addr = 0;
  logic [31:0] im_data, ir;
  logic ir_valid, halted, ir_ready = 0, redirect = 0;
  logic [31:0] mem [0:65535];
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign im_data = mem[im_addr];

  sisc_ifetch dut (
    .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_data(im_data), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic jump(input logic [15:0] a);
    redirect = 1; redirect_addr = a; tick; redirect = 0;
  endtask

  task automatic test_reset;
    rst_f = 0; ir_ready = 1; tick;
    total++; if (im_addr !== 16'h0000) begin bad++; $display("FAIL reset_im_addr got=%h exp=0000", im_addr); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", ir); end
    total++; if (ir_pc !== 16'h0) begin bad++; $display("FAIL reset_ir_pc got=%h exp=0", ir_pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_fetch;
    rst_f = 1; ir_ready = 1; tick;
    total++; if (ir !== 32'h1000_0001 || ir_pc !== 16'd0 || ir_valid !== 1'b1) begin bad++; $display("FAIL fetch0 got ir=%h pc=%h v=%b exp ir=10000001 pc=0000 v=1", ir, ir_pc, ir_valid); end
    total++; if (im_addr !== 16'd1) begin bad++; $display("FAIL fetch0_im_addr got=%h exp=0001", im_addr); end
    tick;
    total++; if (ir !== 32'h1000_0002 || ir_pc !== 16'd1 || ir_valid !== 1'b1) begin bad++; $display("FAIL fetch1 got ir=%h pc=%h v=%b exp ir=10000002 pc=0001 v=1", ir, ir_pc, ir_valid); end
  endtask

  task automatic test_stall;
    logic [31:0] s_ir; logic [15:0] s_pc, s_addr;
    s_ir = ir; s_pc = ir_pc; s_addr = im_addr; ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (ir !== s_ir || ir_pc !== s_pc || im_addr !== s_addr || ir_valid !== 1'b1) begin bad++; $display("FAIL stall%0d got ir=%h pc=%h addr=%h v=%b exp ir=%h pc=%h addr=%h v=1", i, ir, ir_pc, im_addr, ir_valid, s_ir, s_pc, s_addr); end
    end
    ir_ready = 1; tick;
    total++; if (ir_pc !== s_pc + 16'd1 || ir_valid !== 1'b1 || ir !== mem[s_pc + 16'd1]) begin bad++; $display("FAIL stall_release got pc=%h v=%b exp pc=%h v=1", ir_pc, ir_valid, s_pc + 16'd1); end
  endtask

  task automatic test_redirect;
    int n = 0;
    while (im_addr !== 16'd5 && n < 20) begin tick; n++; end
    total++; if (im_addr !== 16'd5) begin bad++; $display("FAIL redirect_wait_pc5 got=%h exp=0005 (timeout)", im_addr); end
    jump(16'h0040);
    total++; if (ir_valid !== 1'b0 || im_addr !== 16'h0040) begin bad++; $display("FAIL redirect_bubble got v=%b addr=%h exp v=0 addr=0040", ir_valid, im_addr); end
    tick;
    total++; if (ir_pc !== 16'h0040 || ir_valid !== 1'b1 || ir !== mem[16'h0040]) begin bad++; $display("FAIL redirect_target got pc=%h v=%b ir=%h exp pc=0040 v=1 ir=%h", ir_pc, ir_valid, ir, mem[16'h0040]); end
  endtask

  task automatic test_wrap;
    jump(16'hFFFF);
    total++; if (im_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr got=%h exp=ffff", im_addr); end
    tick;
    total++; if (ir_pc !== 16'hFFFF || ir_valid !== 1'b1) begin bad++; $display("FAIL wrap_ffff got pc=%h v=%b exp pc=ffff v=1", ir_pc, ir_valid); end
    tick;
    total++; if (ir_pc !== 16'h0000 || im_addr !== 16'h0001 || ir !== mem[0]) begin bad++; $display("FAIL wrap_0000 got pc=%h addr=%h exp pc=0000 addr=0001", ir_pc, im_addr); end
  endtask

  task automatic test_halt;
    mem[3] = 32'hF000_0000;
    jump(16'h0000); tick;
    total++; if (ir_pc !== 16'd0 || ir_valid !== 1'b1) begin bad++; $display("FAIL halt_resume0 got pc=%h v=%b exp pc=0000 v=1", ir_pc, ir_valid); end
    tick; tick; tick;
    total++; if (ir_pc !== 16'd3 || ir !== 32'hF000_0000 || ir_valid !== 1'b1) begin bad++; $display("FAIL halt_word got pc=%h ir=%h v=%b exp pc=0003 ir=f0000000 v=1", ir_pc, ir, ir_valid); end
`ifdef SISC_IFETCH_HALT_EN
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    tick;
    total++; if (ir_valid !== 1'b0 || im_addr !== 16'd4 || halted !== 1'b1) begin bad++; $display("FAIL halt_hold got v=%b addr=%h h=%b exp v=0 addr=0004 h=1", ir_valid, im_addr, halted); end
    tick; tick;
    total++; if (ir_valid !== 1'b0 || im_addr !== 16'd4) begin bad++; $display("FAIL halt_stays got v=%b addr=%h exp v=0 addr=0004", ir_valid, im_addr); end
    jump(16'h0000);
    total++; if (halted !== 1'b0 || im_addr !== 16'd0) begin bad++; $display("FAIL halt_exit got h=%b addr=%h exp h=0 addr=0000", halted, im_addr); end
    tick;
    total++; if (ir_pc !== 16'd0 || ir_valid !== 1'b1) begin bad++; $display("FAIL halt_exit_fetch got pc=%h v=%b exp pc=0000 v=1", ir_pc, ir_valid); end
`else
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL nohalt_flag got=%b exp=0", halted); end
    tick;
    total++; if (ir_pc !== 16'd4 || ir_valid !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL nohalt_next got pc=%h v=%b h=%b exp pc=0004 v=1 h=0", ir_pc, ir_valid, halted); end
`endif
    mem[3] = 32'h1000_0004;
  endtask

  // Stream-level reference: decode must receive consecutive addresses from the last redirect target,
  // every held word must match memory, and a bubble appears exactly once after each redirect.
  task automatic test_random;
    logic [15:0] exp_addr, p_addr, s_pc, s_addr, a;
    logic [31:0] s_ir;
    logic p_redir, p_stall, rdy, rd;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    a = 16'($urandom); jump(a);
    exp_addr = a; p_addr = a; p_redir = 1; p_stall = 0; s_ir = 0; s_pc = 0; s_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      total++; if (ir_valid !== !p_redir) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ir_valid, !p_redir); end
      if (p_redir) begin total++; if (im_addr !== p_addr) begin bad++; $display("FAIL rnd_redir_addr c=%0d got=%h exp=%h", c, im_addr, p_addr); end end
      if (p_stall) begin total++; if (ir !== s_ir || ir_pc !== s_pc || im_addr !== s_addr) begin bad++; $display("FAIL rnd_stall c=%0d got ir=%h pc=%h addr=%h exp ir=%h pc=%h addr=%h", c, ir, ir_pc, im_addr, s_ir, s_pc, s_addr); end end
      if (ir_valid) begin total++; if (ir !== mem[ir_pc]) begin bad++; $display("FAIL rnd_ir c=%0d got=%h exp=%h", c, ir, mem[ir_pc]); end end
      rdy = ($urandom % 10) < 7; rd = ($urandom % 10) == 0;
      a = ($urandom % 4 == 0) ? 16'hFFF0 + 16'($urandom % 16) : 16'($urandom);
      if (ir_valid && rdy) begin
        total++; if (ir_pc !== exp_addr) begin bad++; $display("FAIL rnd_order c=%0d got=%h exp=%h", c, ir_pc, exp_addr); end
        exp_addr = exp_addr + 16'd1;
      end
      if (rd) exp_addr = a;
      p_stall = ir_valid && !rdy && !rd; s_ir = ir; s_pc = ir_pc; s_addr = im_addr;
      p_redir = rd; p_addr = a;
      ir_ready = rdy; redirect = rd; redirect_addr = a;
      tick;
    end
    redirect = 0; ir_ready = 1;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0001 + i;
    jump(16'h1234); tick; tick;
    #2 rst_f = 0; #1;
    total++; if (im_addr !== 16'h0 || ir !== 32'h0 || ir_pc !== 16'h0 || ir_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL async_reset got addr=%h ir=%h pc=%h v=%b h=%b exp all 0", im_addr, ir, ir_pc, ir_valid, halted); end
    tick; rst_f = 1; tick;
    total++; if (ir_pc !== 16'h0 || ir !== 32'h1000_0001 || ir_valid !== 1'b1) begin bad++; $display("FAIL async_reset_refetch got pc=%h ir=%h v=%b exp pc=0000 ir=10000001 v=1", ir_pc, ir, ir_valid); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0001 + i;
    test_reset;
    test_fetch;
    test_stall;
    test_redirect;
    test_wrap;
    test_halt;
    test_random;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
